// File: rtl/logic_gate_pkg.sv
// Shared opcode definitions for the logic gate pipeline.
package logic_gate_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

endpackage

// File: rtl/logic_gate_core.sv
// Combinational bitwise reduction of NUM_IN operands under a selectable op.
module logic_gate_core
  import logic_gate_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 2
) (
  input  logic [OP_W-1:0]         op,
  input  logic [NUM_IN*WIDTH-1:0] operands,
  output logic [WIDTH-1:0]        result,
  output logic                    illegal
);

  logic [WIDTH-1:0] and_r;
  logic [WIDTH-1:0] or_r;
  logic [WIDTH-1:0] xor_r;

  always_comb begin
    and_r = '1;
    or_r  = '0;
    xor_r = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      and_r = and_r & operands[k*WIDTH +: WIDTH];
      or_r  = or_r  | operands[k*WIDTH +: WIDTH];
      xor_r = xor_r ^ operands[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op_e'(op))
      OP_AND:  result = and_r;
      OP_OR:   result = or_r;
      OP_NAND: result = ~and_r;
      OP_NOR:  result = ~or_r;
      OP_XOR:  result = xor_r;
      OP_XNOR: result = ~xor_r;
      OP_NOT:  result = ~operands[WIDTH-1:0];
      OP_RSVD: illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// Registered logic-gate stage with a 2-entry skid buffer (valid/ready).
// Optional beat/illegal counters enabled by LOGIC_GATE_PIPE_STATS_EN.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_op,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_illegal
`ifdef LOGIC_GATE_PIPE_STATS_EN
  ,
  input  logic                    stat_clr,
  output logic [15:0]             stat_beats,
  output logic [15:0]             stat_illegal
`endif
);

  typedef struct packed {
    logic             ill;
    logic [WIDTH-1:0] data;
  } beat_t;

  typedef enum logic [1:0] {
    OCC_0 = 2'd0,
    OCC_1 = 2'd1,
    OCC_2 = 2'd2
  } occ_e;

  occ_e             state, state_n;
  beat_t            main_q, main_n;
  beat_t            skid_q, skid_n;
  beat_t            new_beat;
  logic [WIDTH-1:0] core_result;
  logic             core_illegal;
  logic             accept;
  logic             drain;

  logic_gate_core #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_core (
    .op       (in_op),
    .operands (in_data),
    .result   (core_result),
    .illegal  (core_illegal)
  );

  assign new_beat    = '{ill: core_illegal, data: core_result};
  assign in_ready    = (state != OCC_2);
  assign out_valid   = (state != OCC_0);
  assign out_data    = main_q.data;
  assign out_illegal = main_q.ill;
  assign accept      = in_valid && in_ready;
  assign drain       = out_valid && out_ready;

  // Main always holds the oldest beat; skid only fills when main is stalled.
  always_comb begin
    state_n = state;
    main_n  = main_q;
    skid_n  = skid_q;
    case (state)
      OCC_0: begin
        if (accept) begin
          main_n  = new_beat;
          state_n = OCC_1;
        end
      end
      OCC_1: begin
        if (accept && drain) begin
          main_n = new_beat;
        end else if (accept) begin
          skid_n  = new_beat;
          state_n = OCC_2;
        end else if (drain) begin
          state_n = OCC_0;
        end
      end
      OCC_2: begin
        if (drain) begin
          main_n  = skid_q;
          state_n = OCC_1;
        end
      end
      default: state_n = OCC_0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= OCC_0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_n;
      main_q <= main_n;
      skid_q <= skid_n;
    end
  end

`ifdef LOGIC_GATE_PIPE_STATS_EN
  logic [15:0] beat_cnt;
  logic [15:0] ill_cnt;

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      beat_cnt <= '0;
      ill_cnt  <= '0;
    end else if (drain) begin
      if (beat_cnt != '1) beat_cnt <= beat_cnt + 16'd1;
      if (main_q.ill && (ill_cnt != '1)) ill_cnt <= ill_cnt + 16'd1;
    end
  end

  assign stat_beats   = beat_cnt;
  assign stat_illegal = ill_cnt;
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe (2-operand and 4-operand instances).
module tb_logic_gate_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [2:0]  in_op;
  logic [15:0] in_data;
  logic [7:0]  out_data;

  logic        v4, r4, ov4, oi4;
  logic [2:0]  op4;
  logic [31:0] d4;
  logic [7:0]  od4;

`ifdef LOGIC_GATE_PIPE_STATS_EN
  logic        stat_clr, stat_clr4;
  logic [15:0] stat_beats, stat_illegal, sb4, si4;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [8:0]  sb[$];

  always #5 clk = ~clk;

  logic_gate_pipe #(.WIDTH(8), .NUM_IN(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_illegal(out_illegal)
`ifdef LOGIC_GATE_PIPE_STATS_EN
    , .stat_clr(stat_clr), .stat_beats(stat_beats), .stat_illegal(stat_illegal)
`endif
  );

  logic_gate_pipe #(.WIDTH(8), .NUM_IN(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(v4), .in_ready(r4), .in_op(op4), .in_data(d4),
    .out_valid(ov4), .out_ready(1'b1), .out_data(od4), .out_illegal(oi4)
`ifdef LOGIC_GATE_PIPE_STATS_EN
    , .stat_clr(stat_clr4), .stat_beats(sb4), .stat_illegal(si4)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference for two operands: returns {illegal, data}.
  function automatic logic [8:0] model(input logic [2:0] op, input logic [15:0] d);
    logic [7:0] a, b;
    a = d[7:0];
    b = d[15:8];
    case (op)
      3'd0: return {1'b0, a & b};
      3'd1: return {1'b0, a | b};
      3'd2: return {1'b0, ~(a & b)};
      3'd3: return {1'b0, ~(a | b)};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {1'b0, ~(a ^ b)};
      3'd6: return {1'b0, ~a};
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        check_eq("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          logic [8:0] e;
          e = sb.pop_front();
          check_eq("out_data", out_data, e[7:0]);
          check_eq("out_illegal", out_illegal, e[8]);
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in_op, in_data));
    end
  end

  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int unsigned guard;
    guard    = 0;
    in_op    = op;
    in_data  = {b, a};
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq("accept_wait", in_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] tbl [8];
    logic       acc;
    tbl = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'h00};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_op = '0; in_data = '0;
    v4 = 1'b0; op4 = '0; d4 = '0;
`ifdef LOGIC_GATE_PIPE_STATS_EN
    stat_clr = 1'b0; stat_clr4 = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_illegal", out_illegal, 0);
    check_eq("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // All ops on F0/CC, one at a time, with latency check.
    for (int unsigned op = 0; op < 8; op++) begin
      send(3'(op), 8'hF0, 8'hCC);
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("lat1_valid", out_valid, 1);
      check_eq("op_table", out_data, tbl[op]);
      check_eq("op_illegal", out_illegal, (op == 7) ? 1 : 0);
      @(posedge clk); #1;
    end

    // Four-operand instance: XOR then NOR of 01/02/04/08.
    d4 = {8'h08, 8'h04, 8'h02, 8'h01}; op4 = 3'd4; v4 = 1'b1;
    @(posedge clk); #1 op4 = 3'd3;
    @(negedge clk);
    check_eq("n4_xor", {ov4, od4}, {1'b1, 8'h0F});
    @(posedge clk); #1 v4 = 1'b0;
    @(negedge clk);
    check_eq("n4_nor", {ov4, od4}, {1'b1, 8'hF0});
    @(posedge clk); #1;

    // Backpressure: fill both entries, third beat must wait.
    out_ready = 1'b0;
    send(3'd3, 8'h00, 8'h00);
    send(3'd3, 8'h0F, 8'h00);
    in_op = 3'd3; in_data = 16'hFFFF; in_valid = 1'b1;
    @(negedge clk);
    check_eq("bp_in_ready", in_ready, 0);
    check_eq("bp_hold", {out_valid, out_data}, {1'b1, 8'hFF});
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("bp_hold2", {out_valid, out_data, in_ready}, {1'b1, 8'hFF, 1'b0});
    @(posedge clk); #1 out_ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_nogap", out_valid, 1);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    @(negedge clk);
    check_eq("bp_drained", {out_valid, in_valid}, 2'b00);
    check_eq("bp_sb_empty", sb.size(), 0);
    @(posedge clk); #1;

    // Accept and drain together for 10 cycles.
    for (int unsigned i = 0; i < 10; i++) begin
      in_op = 3'($urandom_range(0, 6)); in_data = 16'($urandom); in_valid = 1'b1;
      @(negedge clk);
      check_eq("stream_in_ready", in_ready, 1);
      if (i > 0) check_eq("stream_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("stream_last", out_valid, 1);
    @(posedge clk); #1;

    // Reset with occupancy 2.
    out_ready = 1'b0;
    send(3'd1, 8'h12, 8'h34);
    send(3'd2, 8'h56, 8'h78);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("occ2_in_ready", in_ready, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_state", {out_valid, in_ready}, 2'b01);
    @(posedge clk); #1 out_ready = 1'b1;
    send(3'd0, 8'hFF, 8'h0F);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("post_rst_beat", {out_valid, out_data}, {1'b1, 8'h0F});
    @(posedge clk); #1;

`ifdef LOGIC_GATE_PIPE_STATS_EN
    stat_clr = 1'b1;
    @(posedge clk); #1 stat_clr = 1'b0;
    for (int unsigned i = 0; i < 5; i++) send(3'(i), 8'hA5, 8'h3C);
    send(3'd7, 8'h01, 8'h02);
    send(3'd7, 8'h03, 8'h04);
    in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    check_eq("stat_beats", stat_beats, 7);
    check_eq("stat_illegal", stat_illegal, 2);
    stat_clr = 1'b1;
    @(posedge clk); #1 stat_clr = 1'b0;
    check_eq("stat_clr", {stat_beats, stat_illegal}, 0);
    force dut.beat_cnt = 16'hFFFF;
    @(posedge clk); #1 release dut.beat_cnt;
    send(3'd1, 8'h00, 8'h01);
    in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    check_eq("stat_sat", stat_beats, 16'hFFFF);
    check_eq("stat_ill_after_sat", stat_illegal, 0);
`endif

    @(negedge clk);
    check_eq("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
